// File: rtl/stage_sequencer.sv
// stage_sequencer: multicycle control FSM for the RV32I core.
// Owns the PC and the instruction register. Sequences FETCH/DECODE/EXEC/MEM/WB,
// runs the ibus/dbus request-acknowledge handshakes with a bounded wait, and
// traps (sticky) on bus timeout or an unrecognised instruction type.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   run_i                 start/continue execution
//   stage_o               current stage (IDLE=0 FETCH=1 DECODE=2 EXEC=3 MEM=4 WB=5 TRAP=7)
//   pc_o, ir_o            current instruction address / instruction register
//   ibus_req_o/ack_i/data_i  instruction fetch handshake (address = pc_o)
//   itype_i, mem_op_i, wb_en_i, branch_i, target_i  decode/execute info
//   dbus_req_o/ack_i      data access handshake
//   rf_we_o, retire_o     write strobe and retire pulse (WB only)
//   instret_o             retired-instruction count
//   trap_o, cause_o       sticky trap flag and cause (1 ibus, 2 illegal, 3 dbus)
module stage_sequencer #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned BUS_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run_i,
  output logic [2:0]  stage_o,
  output logic [31:0] pc_o,
  output logic [31:0] ir_o,
  output logic        ibus_req_o,
  input  logic        ibus_ack_i,
  input  logic [31:0] ibus_data_i,
  input  logic [4:0]  itype_i,
  input  logic        mem_op_i,
  input  logic        wb_en_i,
  input  logic        branch_i,
  input  logic [31:0] target_i,
  output logic        dbus_req_o,
  input  logic        dbus_ack_i,
  output logic        rf_we_o,
  output logic        retire_o,
  output logic [31:0] instret_o,
  output logic        trap_o,
  output logic [1:0]  cause_o
);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StFetch  = 3'd1,
    StDecode = 3'd2,
    StExec   = 3'd3,
    StMem    = 3'd4,
    StWb     = 3'd5,
    StTrap   = 3'd7
  } state_e;

  localparam logic [7:0] TimeoutCnt = 8'(BUS_TIMEOUT);

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] pend_pc_q;
  logic [31:0] ir_q;
  logic [31:0] instret_q;
  logic [7:0]  wait_q;
  logic        trap_q;
  logic [1:0]  cause_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      pc_q      <= RESET_PC;
      pend_pc_q <= RESET_PC;
      ir_q      <= '0;
      instret_q <= '0;
      wait_q    <= '0;
      trap_q    <= 1'b0;
      cause_q   <= 2'd0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (run_i) begin
            state_q <= StFetch;
            wait_q  <= '0;
          end
        end
        StFetch: begin
          // An ack in the timeout cycle still completes the fetch.
          if (ibus_ack_i) begin
            ir_q    <= ibus_data_i;
            state_q <= StDecode;
          end else if (wait_q == TimeoutCnt) begin
            state_q <= StTrap;
            trap_q  <= 1'b1;
            cause_q <= 2'd1;
          end else begin
            wait_q <= wait_q + 8'd1;
          end
        end
        StDecode: begin
          if (itype_i == 5'd0) begin
            state_q <= StTrap;
            trap_q  <= 1'b1;
            cause_q <= 2'd2;
          end else begin
            state_q <= StExec;
          end
        end
        StExec: begin
          pend_pc_q <= branch_i ? {target_i[31:2], 2'b00} : pc_q + 32'd4;
          state_q   <= mem_op_i ? StMem : StWb;
          wait_q    <= '0;
        end
        StMem: begin
          if (dbus_ack_i) begin
            state_q <= StWb;
          end else if (wait_q == TimeoutCnt) begin
            state_q <= StTrap;
            trap_q  <= 1'b1;
            cause_q <= 2'd3;
          end else begin
            wait_q <= wait_q + 8'd1;
          end
        end
        StWb: begin
          pc_q      <= pend_pc_q;
          instret_q <= instret_q + 32'd1;
          state_q   <= run_i ? StFetch : StIdle;
          wait_q    <= '0;
        end
        StTrap: begin
          // Frozen until reset.
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign stage_o    = state_q;
  assign pc_o       = pc_q;
  assign ir_o       = ir_q;
  assign instret_o  = instret_q;
  assign trap_o     = trap_q;
  assign cause_o    = cause_q;
  assign ibus_req_o = (state_q == StFetch);
  assign dbus_req_o = (state_q == StMem);
  assign retire_o   = (state_q == StWb);
  assign rf_we_o    = (state_q == StWb) && wb_en_i;

endmodule

// File: tb/tb_stage_sequencer.sv
// Bench for stage_sequencer: a driver issues instructions with chosen bus wait
// counts and pushes the expected per-cycle stage stream into a queue; a monitor
// pops one entry per active cycle and compares outputs. Trap and reset cases
// are checked directly by the driver.
module tb_stage_sequencer;

  localparam int unsigned TO = 4;
  localparam logic [2:0] SIdle = 3'd0, SFetch = 3'd1, SDecode = 3'd2, SExec = 3'd3,
                         SMem = 3'd4, SWb = 3'd5, STrap = 3'd7;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        run_i = 1'b0;
  logic [2:0]  stage_o;
  logic [31:0] pc_o, ir_o, instret_o;
  logic        ibus_req_o, dbus_req_o, rf_we_o, retire_o, trap_o;
  logic        ibus_ack_i = 1'b0, dbus_ack_i = 1'b0;
  logic [31:0] ibus_data_i = '0, target_i = '0;
  logic [4:0]  itype_i = 5'd1;
  logic        mem_op_i = 1'b0, wb_en_i = 1'b0, branch_i = 1'b0;
  logic [1:0]  cause_o;

  always #5 clk = ~clk;

  stage_sequencer #(.RESET_PC(32'h0000_0000), .BUS_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .run_i(run_i), .stage_o(stage_o), .pc_o(pc_o), .ir_o(ir_o),
    .ibus_req_o(ibus_req_o), .ibus_ack_i(ibus_ack_i), .ibus_data_i(ibus_data_i),
    .itype_i(itype_i), .mem_op_i(mem_op_i), .wb_en_i(wb_en_i), .branch_i(branch_i),
    .target_i(target_i), .dbus_req_o(dbus_req_o), .dbus_ack_i(dbus_ack_i),
    .rf_we_o(rf_we_o), .retire_o(retire_o), .instret_o(instret_o), .trap_o(trap_o),
    .cause_o(cause_o)
  );

  typedef struct {
    logic [2:0]  stage;
    logic [31:0] pc;
    logic [31:0] ir;
    logic [31:0] instret;
    logic        ibus_req;
    logic        dbus_req;
    logic        retire;
    logic        rf_we;
  } exp_t;

  exp_t        expq[$];
  exp_t        mon_e;
  int          checks = 0;
  int          failures = 0;
  bit          mon_en = 1'b0;
  logic [31:0] m_pc, m_instret, m_ir;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic void push(logic [2:0] st, logic [31:0] ir, logic wb);
    exp_t e;
    e.stage    = st;
    e.pc       = m_pc;
    e.ir       = ir;
    e.instret  = m_instret;
    e.ibus_req = (st == SFetch);
    e.dbus_req = (st == SMem);
    e.retire   = (st == SWb);
    e.rf_we    = (st == SWb) && wb;
    expq.push_back(e);
  endfunction

  // Monitor: one expectation per active (non-IDLE, non-TRAP) cycle.
  always @(negedge clk) begin
    if (mon_en && stage_o != SIdle && stage_o != STrap) begin
      if (expq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_activity: stage %0d with nothing expected", stage_o);
      end else begin
        mon_e = expq.pop_front();
        check("stage", {29'd0, stage_o}, {29'd0, mon_e.stage});
        check("pc", pc_o, mon_e.pc);
        check("ibus_req", {31'd0, ibus_req_o}, {31'd0, mon_e.ibus_req});
        check("dbus_req", {31'd0, dbus_req_o}, {31'd0, mon_e.dbus_req});
        check("retire", {31'd0, retire_o}, {31'd0, mon_e.retire});
        check("rf_we", {31'd0, rf_we_o}, {31'd0, mon_e.rf_we});
        if (mon_e.stage != SFetch) check("ir", ir_o, mon_e.ir);
        if (mon_e.stage == SWb) check("instret_at_wb", instret_o, mon_e.instret);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic ack_noise);
    reset       = 1'b1;
    run_i       = 1'b0;
    ibus_ack_i  = ack_noise;
    dbus_ack_i  = ack_noise;
    ibus_data_i = $urandom;
    step();
    reset      = 1'b0;
    ibus_ack_i = 1'b0;
    dbus_ack_i = 1'b0;
    m_pc = 32'h0; m_instret = 32'h0; m_ir = 32'h0;
    expq.delete();
    check("rst_stage", {29'd0, stage_o}, {29'd0, SIdle});
    check("rst_pc", pc_o, 32'h0);
    check("rst_ir", ir_o, 32'h0);
    check("rst_instret", instret_o, 32'h0);
    check("rst_trap", {31'd0, trap_o}, 32'h0);
    check("rst_cause", {30'd0, cause_o}, 32'h0);
    check("rst_strobes", {28'd0, ibus_req_o, dbus_req_o, rf_we_o, retire_o}, 32'h0);
  endtask

  task automatic start_if_idle();
    if (stage_o == SIdle) begin
      run_i = 1'b1;
      step();
    end
  endtask

  task automatic do_instr(input logic [31:0] data, input logic [4:0] itype, input logic mem,
                          input logic wb, input logic br, input logic [31:0] tgt,
                          input int iwait, input int dwait, input logic run_after);
    // Expected stream from the stage rules.
    repeat (iwait + 1) push(SFetch, data, wb);
    push(SDecode, data, wb);
    push(SExec, data, wb);
    if (mem) repeat (dwait + 1) push(SMem, data, wb);
    push(SWb, data, wb);
    m_pc      = br ? (tgt & 32'hFFFF_FFFC) : m_pc + 32'd4;
    m_instret = m_instret + 32'd1;
    m_ir      = data;
    // Drive.
    ibus_data_i = data; itype_i = itype; mem_op_i = mem; wb_en_i = wb;
    branch_i = br; target_i = tgt;
    start_if_idle();
    repeat (iwait) begin
      dbus_ack_i = 1'($urandom);
      step();
    end
    dbus_ack_i = 1'b0;
    ibus_ack_i = 1'b1;
    step();
    // Stray ibus acks with junk data must be ignored from here on.
    ibus_ack_i  = 1'($urandom);
    ibus_data_i = $urandom;
    step();
    run_i = run_after;
    step();
    if (mem) begin
      repeat (dwait) step();
      dbus_ack_i = 1'b1;
      step();
      dbus_ack_i = 1'b0;
    end
    ibus_ack_i = 1'b0;
    step();
  endtask

  task automatic trap_ibus();
    start_if_idle();
    repeat (TO + 1) push(SFetch, m_ir, 1'b0);
    ibus_ack_i = 1'b0;
    repeat (TO + 1) step();
    check("tmo_i_stage", {29'd0, stage_o}, {29'd0, STrap});
    check("tmo_i_trap", {31'd0, trap_o}, 32'h1);
    check("tmo_i_cause", {30'd0, cause_o}, 32'h1);
    check("tmo_i_req", {31'd0, ibus_req_o}, 32'h0);
    ibus_ack_i  = 1'b1;
    ibus_data_i = $urandom;
    step();
    step();
    ibus_ack_i = 1'b0;
    check("trap_frozen_ir", ir_o, m_ir);
    check("trap_frozen_pc", pc_o, m_pc);
    check("trap_stays", {29'd0, stage_o}, {29'd0, STrap});
    check("trap_no_retire", {31'd0, retire_o}, 32'h0);
    check("queue_drained", expq.size(), 32'h0);
  endtask

  task automatic trap_illegal(input logic [31:0] data);
    start_if_idle();
    push(SFetch, data, 1'b1);
    push(SDecode, data, 1'b1);
    m_ir = data;
    ibus_data_i = data; itype_i = 5'd0; wb_en_i = 1'b1; mem_op_i = 1'b0;
    ibus_ack_i = 1'b1;
    step();
    ibus_ack_i = 1'b0;
    step();
    check("ill_stage", {29'd0, stage_o}, {29'd0, STrap});
    check("ill_cause", {30'd0, cause_o}, 32'h2);
    check("ill_trap", {31'd0, trap_o}, 32'h1);
    check("ill_instret", instret_o, m_instret);
    check("ill_pc", pc_o, m_pc);
    check("ill_ir", ir_o, data);
    check("queue_drained", expq.size(), 32'h0);
    itype_i = 5'd1;
  endtask

  task automatic trap_dbus(input logic [31:0] data);
    start_if_idle();
    push(SFetch, data, 1'b0);
    push(SDecode, data, 1'b0);
    push(SExec, data, 1'b0);
    repeat (TO + 1) push(SMem, data, 1'b0);
    m_ir = data;
    ibus_data_i = data; itype_i = 5'd3; mem_op_i = 1'b1; branch_i = 1'b0;
    ibus_ack_i = 1'b1;
    step();
    ibus_ack_i = 1'b0;
    step();
    step();
    repeat (TO + 1) step();
    check("tmo_d_stage", {29'd0, stage_o}, {29'd0, STrap});
    check("tmo_d_cause", {30'd0, cause_o}, 32'h3);
    check("tmo_d_req", {31'd0, dbus_req_o}, 32'h0);
    check("tmo_d_instret", instret_o, m_instret);
    check("queue_drained", expq.size(), 32'h0);
  endtask

  initial begin
    do_reset(1'b1);
    mon_en = 1'b1;

    // Plain R-type, zero waits.
    do_instr(32'h0020_81B3, 5'd1, 1'b0, 1'b1, 1'b0, 32'h0, 0, 0, 1'b1);
    check("first_pc", pc_o, 32'h4);
    check("first_instret", instret_o, 32'h1);
    check("back_to_back", {29'd0, stage_o}, {29'd0, SFetch});
    // Load with dbus ack delayed 3 cycles.
    do_instr(32'h0000_A103, 5'd2, 1'b1, 1'b1, 1'b0, 32'h0, 0, 3, 1'b1);
    // Branch to unaligned target.
    do_instr(32'h0000_0063, 5'd4, 1'b0, 1'b0, 1'b1, 32'h0000_0103, 1, 0, 1'b1);
    check("branch_pc", pc_o, 32'h0000_0100);
    // PC wrap.
    do_instr(32'h0000_006F, 5'd5, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFE, 0, 0, 1'b1);
    do_instr(32'h0000_0013, 5'd1, 1'b0, 1'b1, 1'b0, 32'h0, 0, 0, 1'b1);
    check("pc_wrap", pc_o, 32'h0);
    // Ack on the last permitted cycle: no trap.
    do_instr(32'h1234_5013, 5'd1, 1'b1, 1'b0, 1'b0, 32'h0, TO, TO, 1'b1);
    check("edge_no_trap", {31'd0, trap_o}, 32'h0);
    // run_i drops during MEM: completes then parks.
    do_instr(32'h0000_2023, 5'd6, 1'b1, 1'b0, 1'b0, 32'h0, 0, 2, 1'b0);
    check("park_idle", {29'd0, stage_o}, {29'd0, SIdle});

    for (int n = 0; n < 40; n++) begin
      do_instr($urandom, 5'($urandom_range(1, 31)), 1'($urandom), 1'($urandom),
               ($urandom_range(0, 3) == 0), $urandom, $urandom_range(0, TO),
               $urandom_range(0, TO), ($urandom_range(0, 4) != 0));
    end
    check("rand_instret", instret_o, m_instret);
    check("rand_pc", pc_o, m_pc);

    trap_ibus();
    do_reset(1'b0);
    do_instr(32'h0000_0033, 5'd1, 1'b0, 1'b1, 1'b0, 32'h0, 0, 0, 1'b1);
    trap_illegal(32'hDEAD_BEEF);
    do_reset(1'b0);
    trap_dbus(32'h0000_2083);

    // Reset mid-fetch with an ack in the reset cycle.
    do_reset(1'b0);
    run_i = 1'b1;
    step();
    push(SFetch, 32'h0, 1'b0);
    do_reset(1'b1);

    mon_en = 1'b0;
    check("final_queue_empty", expq.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stage_sequencer.md
# stage_sequencer

Multicycle control FSM for the RV32I core. It owns the PC and instruction register, drives the 3-bit stage select consumed by the decode/register-file stage, and runs the instruction- and data-bus request/acknowledge handshakes. It also generates the register-file write strobe and the retire pulse, and traps on bus timeout or illegal instruction type.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- BUS_TIMEOUT, 255, max wait cycles (1..255) for ibus/dbus ack before trap
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- run_i  in  1  start/continue execution
- stage_o  out  3  IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, TRAP=7
- pc_o  out  32  current instruction address
- ir_o  out  32  instruction register, feeds decode ir_i
- ibus_req_o  out  1  instruction fetch request (address = pc_o)
- ibus_ack_i  in  1  fetch complete, ibus_data_i valid
- ibus_data_i  in  32  fetched instruction
- itype_i  in  5  instruction type from decode; 0 = unrecognised
- mem_op_i  in  1  instruction needs data-bus access (load/store)
- wb_en_i  in  1  instruction writes rd
- branch_i  in  1  taken branch/jump at EXEC
- target_i  in  32  branch target
- dbus_req_o  out  1  data access request
- dbus_ack_i  in  1  data access complete
- rf_we_o  out  1  register-file write strobe
- retire_o  out  1  one-cycle pulse per completed instruction
- instret_o  out  32  retired-instruction count
- trap_o  out  1  sticky trap flag
- cause_o  out  2  0 none, 1 ibus timeout, 2 illegal itype, 3 dbus timeout

## Operation
- Reset values: stage IDLE, pc_o=RESET_PC, ir_o=0, instret_o=0, trap_o=0, cause_o=0. All strobes and requests are 0.
- Reset is taken in any state, including mid-handshake. An ack arriving in the reset cycle is ignored.
- IDLE: run_i=1 moves to FETCH on the next cycle.
- FETCH: ibus_req_o=1. On ibus_ack_i, ir_o<=ibus_data_i and the FSM moves to DECODE.
- DECODE: one cycle. itype_i==0 sends the FSM to TRAP with cause 2. Otherwise it moves to EXEC.
- EXEC: one cycle. On branch_i, a pending-PC register latches {target_i[31:2],2'b00}; otherwise it latches pc_o+4, wrapping modulo 2^32. mem_op_i=1 goes to MEM, else WB.
- MEM: dbus_req_o=1 until dbus_ack_i, then WB.
- WB: rf_we_o=wb_en_i, retire_o=1, pc_o<=pending PC, instret_o+=1 (wraps 0xFFFF_FFFF to 0). Goes to FETCH if run_i=1, else IDLE.
- Timeout: an 8-bit wait counter clears on entry to FETCH/MEM and increments each cycle without ack. If it equals BUS_TIMEOUT with no ack in that cycle, the FSM enters TRAP with cause 1 (FETCH) or 3 (MEM). An ack in the same cycle wins over timeout.
- TRAP: trap_o=1, all requests/strobes 0, pc_o/ir_o frozen. Only reset exits.
- Acks outside a request state are ignored.
- run_i dropping mid-instruction does not abort; the instruction completes and the FSM parks in IDLE.

## Timing
- stage_o, pc_o, ir_o, instret_o, trap_o, cause_o are registered.
- ibus_req_o, dbus_req_o, rf_we_o, retire_o are decoded from the current state (Moore), with no input-to-output combinational path except rf_we_o from wb_en_i.
- Non-memory instruction with zero-wait ack: 4 cycles (FETCH, DECODE, EXEC, WB).
- Memory instruction with zero-wait ack: 5 cycles. Each wait cycle adds one.
- Back-to-back instructions: FETCH follows WB directly, with no bubble.
- A request stays asserted and the address stays stable until the ack cycle. The request drops in the cycle after the ack.

## Test plan
- Reset then run_i=1, ibus acks immediately, itype=R, wb_en=1 -> stage 0,1,2,3,5,1; rf_we_o and retire_o high in the WB cycle; pc 0x0 to 0x4; instret_o=1.
- Load with mem_op_i=1, dbus ack delayed 3 cycles -> MEM lasts 4 cycles, dbus_req_o high throughout; total 8 cycles.
- branch_i=1, target_i=0x0000_0103 at EXEC -> next fetch address 0x0000_0100.
- No ibus ack with BUS_TIMEOUT=4 -> TRAP with cause 1 after the 5th FETCH cycle; ibus_req_o low afterwards. Repeat with ack on exactly that cycle -> no trap.
- itype_i=0 in DECODE -> TRAP with cause 2, instret_o unchanged; then reset -> IDLE, pc=RESET_PC, trap_o=0.
- pc_o=0xFFFF_FFFC, no branch -> wraps to 0x0. Preload instret_o near wrap: 0xFFFF_FFFF -> 0. Drop run_i during MEM -> instruction retires, then IDLE.
